// File: rtl/acc_exec_unit_if.sv
// Operand/command and write-back bundle between the accumulator register file
// and the execute stage.
interface acc_exec_unit_if #(parameter int W = 8);
  logic         Start;
  logic [3:0]   Op;
  logic [W-1:0] Acc;
  logic [W-1:0] Operand;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic         WriteEn;
  logic         WriteR0;
  logic         Carry;
  logic         Zero;
  logic         Illegal;

  modport master (
    output Start, Op, Acc, Operand,
    input  Busy, Done, Result, WriteEn, WriteR0, Carry, Zero, Illegal
  );

  modport slave (
    input  Start, Op, Acc, Operand,
    output Busy, Done, Result, WriteEn, WriteR0, Carry, Zero, Illegal
  );
endinterface

// File: rtl/acc_exec_unit.sv
// Multi-cycle accumulator execute stage: single-cycle ALU/moves, iterative
// shifts and shift-add multiply, writing back into the accumulator register file.
//
// state | meaning
// IDLE  | waiting for Start; operands latched on the accepting edge
// SHIFT | one bit of SHL/SHR per cycle, cnt bits remaining
// MUL   | one multiplier bit per cycle, W cycles
// WB_LO | multiply low byte written to R0
// WB_HI | final write-back, Done pulse, flags visible
module acc_exec_unit #(
  parameter int W  = 8,
  parameter int CW = 3
) (
  input logic            Clk,
  input logic            Reset,
  acc_exec_unit_if.slave bus
);
  localparam int MCW = $clog2(W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MOVR = 4'd5;
  localparam logic [3:0] OP_MOVA = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  typedef enum logic [2:0] {IDLE, SHIFT, MUL, WB_LO, WB_HI} state_t;

  state_t         st, st_d;
  logic [3:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [CW-1:0]  cnt;
  logic [MCW-1:0] mcnt;
  logic [2*W-1:0] p, p_next, addend;
  logic [W-1:0]   result_q, res_d, sh_a;
  logic           carry_q, zero_q, we_q, wr0_q, ill_q;
  logic           ld_res, ld_c, ld_z, c_d, z_d, we_d, wr0_d, ill_d, sh_out;
  logic [W:0]     sum, diff;

  assign sum    = {1'b0, bus.Acc} + {1'b0, bus.Operand};
  assign diff   = {1'b0, bus.Acc} - {1'b0, bus.Operand};
  assign sh_a   = (op_q == OP_SHL) ? (a_q << 1) : (a_q >> 1);
  assign sh_out = (op_q == OP_SHL) ? a_q[W-1] : a_q[0];
  assign addend = {{W{1'b0}}, a_q} << mcnt;
  assign p_next = b_q[mcnt] ? (p + addend) : p;

  always_comb begin
    st_d   = st;
    ld_res = 1'b0;
    res_d  = result_q;
    ld_c   = 1'b0;
    c_d    = carry_q;
    ld_z   = 1'b0;
    we_d   = 1'b0;
    wr0_d  = 1'b0;
    ill_d  = 1'b0;
    case (st)
      IDLE: if (bus.Start) begin
        st_d = WB_HI;
        case (bus.Op)
          OP_ADD:  begin res_d = sum[W-1:0];  c_d = sum[W];  ld_res = 1'b1; ld_c = 1'b1; ld_z = 1'b1; wr0_d = 1'b1; end
          OP_SUB:  begin res_d = diff[W-1:0]; c_d = diff[W]; ld_res = 1'b1; ld_c = 1'b1; ld_z = 1'b1; wr0_d = 1'b1; end
          OP_AND:  begin res_d = bus.Acc & bus.Operand; c_d = 1'b0; ld_res = 1'b1; ld_c = 1'b1; ld_z = 1'b1; wr0_d = 1'b1; end
          OP_OR:   begin res_d = bus.Acc | bus.Operand; c_d = 1'b0; ld_res = 1'b1; ld_c = 1'b1; ld_z = 1'b1; wr0_d = 1'b1; end
          OP_XOR:  begin res_d = bus.Acc ^ bus.Operand; c_d = 1'b0; ld_res = 1'b1; ld_c = 1'b1; ld_z = 1'b1; wr0_d = 1'b1; end
          OP_MOVR: begin res_d = bus.Acc;     ld_res = 1'b1; we_d = 1'b1; end
          OP_MOVA: begin res_d = bus.Operand; ld_res = 1'b1; ld_z = 1'b1; wr0_d = 1'b1; end
          OP_SHL, OP_SHR: begin
            if (bus.Operand[CW-1:0] == '0) begin
              res_d = bus.Acc; c_d = 1'b0; ld_res = 1'b1; ld_c = 1'b1; ld_z = 1'b1; wr0_d = 1'b1;
            end else begin
              st_d = SHIFT;
            end
          end
          OP_MUL:  st_d = MUL;
          default: ill_d = 1'b1;
        endcase
      end
      SHIFT: if (cnt == CW'(1)) begin
        st_d = WB_HI; res_d = sh_a; c_d = sh_out;
        ld_res = 1'b1; ld_c = 1'b1; ld_z = 1'b1; wr0_d = 1'b1;
      end
      MUL: if (mcnt == MCW'(W-1)) begin
        st_d = WB_LO; res_d = p_next[W-1:0]; ld_res = 1'b1; wr0_d = 1'b1;
      end
      WB_LO: begin
        st_d = WB_HI; res_d = p[2*W-1:W]; c_d = (p[2*W-1:W] != '0);
        ld_res = 1'b1; ld_c = 1'b1; ld_z = 1'b1; we_d = 1'b1;
      end
      WB_HI: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    // Multiply judges Zero on the whole product, not just the high byte written last.
    z_d = (st == WB_LO) ? (p == '0) : (res_d == '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st       <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      mcnt     <= '0;
      p        <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      we_q     <= 1'b0;
      wr0_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      st <= st_d;
      if (st == IDLE && bus.Start) begin
        op_q <= bus.Op;
        a_q  <= bus.Acc;
        b_q  <= bus.Operand;
        cnt  <= bus.Operand[CW-1:0];
        mcnt <= '0;
        p    <= '0;
      end else if (st == SHIFT) begin
        a_q <= sh_a;
        cnt <= cnt - CW'(1);
      end else if (st == MUL) begin
        p    <= p_next;
        mcnt <= mcnt + MCW'(1);
      end
      if (ld_res) result_q <= res_d;
      if (ld_c)   carry_q  <= c_d;
      if (ld_z)   zero_q   <= z_d;
      we_q  <= we_d;
      wr0_q <= wr0_d;
      ill_q <= ill_d;
    end
  end

  assign bus.Busy    = (st != IDLE);
  assign bus.Done    = (st == WB_HI);
  assign bus.Result  = result_q;
  assign bus.WriteEn = we_q;
  assign bus.WriteR0 = wr0_q;
  assign bus.Carry   = carry_q;
  assign bus.Zero    = zero_q;
  assign bus.Illegal = ill_q;
endmodule

// File: doc/acc_exec_unit.md
Name: acc_exec_unit

Overview:
- Multi-cycle accumulator execute stage, directly downstream of the 8-bit, 16-entry accumulator register file.
- Consumes R0 (DataOut0) as the accumulator operand and the addressed register Rn (DataOut) as the second operand.
- Produces the write-back byte and the WriteEn/WriteR0 strobes that feed the register file's DataIn.
- Single-cycle ALU ops, iterative shifts and an 8-cycle shift-add multiply sit behind a Start/Busy/Done handshake.

Parameters:
- W, 8, data path width; must match the register file.
- CW, 3, shift-count width; shift amount is Operand[CW-1:0].

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request; sampled only in IDLE.
- Op  in  4  operation code, sampled with Start.
- Acc  in  W  R0 value (register file DataOut0).
- Operand  in  W  Rn value (register file DataOut).
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle completion pulse.
- Result  out  W  write-back data to the register file's DataIn.
- WriteEn  out  1  write Result to Rn; never high together with WriteR0.
- WriteR0  out  1  write Result to R0.
- Carry  out  1  carry flag, registered.
- Zero  out  1  zero flag, registered.
- Illegal  out  1  one-cycle pulse, concurrent with Done, for undefined Op.

Behaviour:
- Reset (any state, including mid-operation):
  - state IDLE; Busy, Done, WriteEn, WriteR0, Illegal, Carry, Zero = 0; Result = 0.
  - Internal counters and product cleared.
  - An aborted op produces no write and no Done.
- Operand capture:
  - On a rising edge with state=IDLE and Start=1, Acc, Operand and Op are latched.
  - Later input changes are ignored until the next accepted Start.
  - Start while Busy is ignored, not queued.
- Register address: upstream holds the register file's Reg address stable from Start until Done.
- States: IDLE, SHIFT, MUL, WB_LO, WB_HI.
- Op codes and routing:
  - 0 ADD: R0 <- A+B. Carry = bit-8 carry-out.
  - 1 SUB: R0 <- A-B. Carry = borrow, i.e. A<B unsigned.
  - 2 AND, 3 OR, 4 XOR: R0 <- A op B. Carry = 0.
  - 5 MOVR: Rn <- A via WriteEn. Flags unchanged.
  - 6 MOVA: R0 <- B via WriteR0. Zero updated; Carry unchanged.
  - 7 SHL, 8 SHR: R0 <- A shifted logically by n = B[CW-1:0].
    - One bit per cycle in SHIFT.
    - n=0 goes straight to WB_HI with Result=A, Carry=0.
    - Otherwise Carry = last bit shifted out.
  - 9 MUL: unsigned A*B, 16-bit product P via shift-add, one multiplier bit per cycle.
    - Exactly 8 MUL cycles, then WB_LO, then WB_HI.
    - WB_LO: Result=P[7:0], WriteR0=1, Done=0.
    - WB_HI: Result=P[15:8], WriteEn=1, Done=1.
    - Carry = (P[15:8]!=0); Zero = (P==0).
  - 10-15: straight to WB_HI. No write, Done=1, Illegal=1, flags unchanged.
- Transitions from IDLE:
  - ALU/MOV/illegal ops -> WB_HI.
  - Shift with n>0 -> SHIFT; from SHIFT -> WB_HI after n cycles.
  - MUL -> MUL (8 cycles) -> WB_LO -> WB_HI.
- WB_HI:
  - Drives Result and exactly one write strobe (or none for illegal Op).
  - Done=1 for exactly that cycle; next state IDLE.
- Latency (Start edge to the Done cycle):
  - ALU/MOV/illegal: 1 cycle.
  - Shift: 1+n cycles.
  - MUL: 10 cycles.
- Back-to-back: Busy=0 in the cycle after Done, so the next Start can be accepted on that edge.
- Outputs outside write-back cycles: WriteEn, WriteR0 and Done = 0; Result holds its last value.
- Flags:
  - Update only on the Done cycle.
  - Zero = (written value == 0), except MUL, which uses the full P.
- Arithmetic: all unsigned, modulo 2^W; no saturation.

Test Plan:
- Reset mid-MUL (after 4 MUL cycles): next cycle Busy=0; no WriteR0/WriteEn/Done ever pulses for that op; Carry=Zero=0.
- ADD A=0xF0, B=0x20: Done 1 cycle after Start; WriteR0=1, Result=0x10, Carry=1, Zero=0. Then SUB A=0x05, B=0x05: Result=0x00, Carry=0, Zero=1.
- SHL A=0x81, B=0x03: Busy for 4 cycles; Done on cycle 4; Result=0x08, Carry=0. Then SHR A=0x81, B=0x00: latency 1, Result=0x81, Carry=0.
- MUL A=0xFF, B=0xFF:
  - cycle 9: WriteR0 with Result=0x01;
  - cycle 10: WriteEn with Result=0xFE, Done=1, Carry=1, Zero=0;
  - both strobes never high together.
- Start pulsed every cycle during a MUL, with Acc/Operand toggling: exactly one op executes, on the latched values; the next op is accepted only on the edge after Done.
- Op=12: Done and Illegal high 1 cycle after Start; no write strobes; Carry/Zero retain prior values. MOVR A=0x5A: WriteEn=1, Result=0x5A, flags unchanged.
